// File: rtl/w_slice_bcast.sv
// Weight slice broadcaster: holds one packed weight word and emits it as broadcast
// beats (one element, two elements, or the whole word per beat) through a registered output.
module w_slice_bcast #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  localparam int WORD_W = LANES * ELEM_W,
  localparam int PTR_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [2:0]        input_bitwidth,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              out_last,
  output logic              err_mode,
  output logic [15:0]       skip_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, SLICE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [2:0]          mode_q, mode_d;
  logic [WORD_W-1:0]   dout_q, dout_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [15:0]         skip_q, skip_d;

  logic                load_ok_s;
  logic                cur_last_s;
  logic                in_ready_s;
  logic                acc_s;
  logic                word_zero_s;
  logic                mode_bad_s;

  // Index of the final beat of a word for a given (legal) mode.
  function automatic logic [PTR_W-1:0] last_idx(input logic [2:0] m);
    logic [PTR_W-1:0] r;
    case (m)
      3'b100:  r = PTR_W'(LANES - 1);
      3'b010:  r = PTR_W'(LANES / 2 - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Build beat p of word w: replicate one element, replicate a pair per half, or pass through.
  function automatic logic [WORD_W-1:0] make_beat(input logic [WORD_W-1:0] w,
                                                  input logic [2:0]        m,
                                                  input logic [PTR_W-1:0]  p);
    logic [WORD_W-1:0] b;
    logic [ELEM_W-1:0] e_lo;
    logic [ELEM_W-1:0] e_hi;
    int                pi;
    pi   = int'(p);
    b    = '0;
    e_lo = '0;
    e_hi = '0;
    case (m)
      3'b100: begin
        e_lo = w[pi*ELEM_W +: ELEM_W];
        for (int k = 0; k < LANES; k++) b[k*ELEM_W +: ELEM_W] = e_lo;
      end
      3'b010: begin
        e_lo = w[(2*pi)*ELEM_W +: ELEM_W];
        e_hi = w[(2*pi+1)*ELEM_W +: ELEM_W];
        for (int k = 0; k < LANES / 2; k++) begin
          b[k*ELEM_W +: ELEM_W]               = e_lo;
          b[(k+LANES/2)*ELEM_W +: ELEM_W]     = e_hi;
        end
      end
      default: b = w;
    endcase
    return b;
  endfunction

  assign load_ok_s   = !vld_q || out_ready;
  assign cur_last_s  = (rd_ptr_q == last_idx(mode_q));
  assign in_ready_s  = (state_q == IDLE) || (load_ok_s && cur_last_s);
  assign acc_s       = in_valid && in_ready_s;
  assign word_zero_s = (data_in == '0);
  assign mode_bad_s  = !$onehot(input_bitwidth);

  // Next-state: advance the held word, then overlay the effect of an accepted word.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    word_d   = word_q;
    mode_d   = mode_q;
    dout_d   = dout_q;
    vld_d    = vld_q && !out_ready;
    last_d   = last_q;
    err_d    = 1'b0;
    skip_d   = skip_q;

    case (state_q)
      SLICE: begin
        if (load_ok_s) begin
          dout_d = make_beat(word_q, mode_q, rd_ptr_q);
          vld_d  = 1'b1;
          last_d = cur_last_s;
          if (cur_last_s) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      IDLE: begin
        rd_ptr_d = '0;
      end
      default: begin
        state_d  = IDLE;
        rd_ptr_d = '0;
      end
    endcase

    if (acc_s) begin
      if (word_zero_s) begin
        if (skip_q != 16'hFFFF) begin
          skip_d = skip_q + 16'd1;
        end else begin
          skip_d = skip_q;
        end
      end else if (mode_bad_s) begin
        err_d = 1'b1;
      end else begin
        word_d = data_in;
        mode_d = input_bitwidth;
        // From IDLE with a free output register the first beat goes out next cycle.
        if ((state_q == IDLE) && load_ok_s) begin
          dout_d = make_beat(data_in, input_bitwidth, '0);
          vld_d  = 1'b1;
          last_d = (last_idx(input_bitwidth) == '0);
          if (last_idx(input_bitwidth) == '0) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
          end else begin
            state_d  = SLICE;
            rd_ptr_d = PTR_W'(1);
          end
        end else begin
          state_d  = SLICE;
          rd_ptr_d = '0;
        end
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      word_q   <= '0;
      mode_q   <= 3'b000;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      skip_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      word_q   <= word_d;
      mode_q   <= mode_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = vld_q;
  assign data_out  = dout_q;
  assign out_last  = last_q;
  assign err_mode  = err_q;
  assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_w_slice_bcast.sv
// Directed bench for w_slice_bcast (LANES=4, ELEM_W=8) with hand-computed beats.
module tb_w_slice_bcast;
  localparam int LANES  = 4;
  localparam int ELEM_W = 8;
  localparam int WORD_W = LANES * ELEM_W;

  logic              clk = 1'b0;
  logic              nRST;
  logic [2:0]        input_bitwidth;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] data_out;
  logic              out_last;
  logic              err_mode;
  logic [15:0]       skip_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  w_slice_bcast #(.LANES(LANES), .ELEM_W(ELEM_W)) dut (
    .clk(clk), .nRST(nRST), .input_bitwidth(input_bitwidth), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_last(out_last), .err_mode(err_mode), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [WORD_W-1:0] d);
    input_bitwidth = m;
    data_in        = d;
    in_valid       = 1'b1;
    tick();
    in_valid       = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [WORD_W-1:0] d, input logic l);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, ".data"},  64'(data_out),  64'(d));
    check_eq({tag, ".last"},  64'(out_last),  64'(l));
  endtask

  task automatic expect_idle_out(input string tag);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    nRST           = 1'b0;
    input_bitwidth = 3'b100;
    in_valid       = 1'b0;
    data_in        = '0;
    out_ready      = 1'b1;
    tick();
    tick();
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.data",  64'(data_out),  64'd0);
    check_eq("rst.last",  64'(out_last),  64'd0);
    check_eq("rst.err",   64'(err_mode),  64'd0);
    check_eq("rst.skip",  64'(skip_cnt),  64'd0);
    nRST = 1'b1;
    tick();
    check_eq("rst.in_ready", 64'(in_ready), 64'd1);

    // Mode 100: one element per beat, in_ready drops until the last beat loads.
    send(3'b100, 32'h44332211);
    expect_beat("m8.b0", 32'h11111111, 1'b0);
    check_eq("m8.rdy0", 64'(in_ready), 64'd0);
    tick();
    expect_beat("m8.b1", 32'h22222222, 1'b0);
    check_eq("m8.rdy1", 64'(in_ready), 64'd0);
    tick();
    expect_beat("m8.b2", 32'h33333333, 1'b0);
    check_eq("m8.rdy2", 64'(in_ready), 64'd1);
    tick();
    expect_beat("m8.b3", 32'h44444444, 1'b1);
    tick();
    expect_idle_out("m8.after");

    // Mode 010 and mode 001.
    send(3'b010, 32'hDDCCBBAA);
    expect_beat("m4.b0", 32'hBBBBAAAA, 1'b0);
    tick();
    expect_beat("m4.b1", 32'hDDDDCCCC, 1'b1);
    tick();
    expect_idle_out("m4.after");
    send(3'b001, 32'h12345678);
    expect_beat("m2.b0", 32'h12345678, 1'b1);
    tick();
    expect_idle_out("m2.after");

    // Back-to-back mode 010 words with no bubble.
    input_bitwidth = 3'b010;
    data_in        = 32'hDDCCBBAA;
    in_valid       = 1'b1;
    tick();
    data_in        = 32'h87654321;
    check_eq("b2b.rdy", 64'(in_ready), 64'd1);
    expect_beat("b2b.w0b0", 32'hBBBBAAAA, 1'b0);
    tick();
    in_valid = 1'b0;
    expect_beat("b2b.w0b1", 32'hDDDDCCCC, 1'b1);
    tick();
    expect_beat("b2b.w1b0", 32'h43432121, 1'b0);
    tick();
    expect_beat("b2b.w1b1", 32'h87876565, 1'b1);
    tick();
    expect_idle_out("b2b.after");

    // Backpressure on beat 1 while the input mode changes.
    send(3'b100, 32'h44332211);
    expect_beat("bp.b0", 32'h11111111, 1'b0);
    tick();
    out_ready      = 1'b0;
    input_bitwidth = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_beat("bp.hold", 32'h22222222, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    expect_beat("bp.b2", 32'h33333333, 1'b0);
    tick();
    expect_beat("bp.b3", 32'h44444444, 1'b1);
    tick();
    expect_idle_out("bp.after");

    // Zero words are skipped; a later real word starts the next cycle.
    send(3'b100, 32'h0);
    expect_idle_out("z.0");
    send(3'b100, 32'h0);
    expect_idle_out("z.1");
    check_eq("z.skip2", 64'(skip_cnt), 64'd2);
    send(3'b100, 32'h000000FF);
    expect_beat("z.b0", 32'hFFFFFFFF, 1'b0);
    tick();
    expect_beat("z.b1", 32'h00000000, 1'b0);
    tick();
    expect_beat("z.b2", 32'h00000000, 1'b0);
    tick();
    expect_beat("z.b3", 32'h00000000, 1'b1);
    check_eq("z.skip_keep", 64'(skip_cnt), 64'd2);
    tick();

    // Illegal mode: error pulse, no beats, no skip count.
    send(3'b011, 32'h01020304);
    check_eq("bad.err", 64'(err_mode), 64'd1);
    expect_idle_out("bad.nobeat");
    check_eq("bad.skip", 64'(skip_cnt), 64'd2);
    tick();
    check_eq("bad.err_clr", 64'(err_mode), 64'd0);
    expect_idle_out("bad.nobeat2");

    // Zero check wins over mode check.
    send(3'b011, 32'h0);
    check_eq("prio.err", 64'(err_mode), 64'd0);
    check_eq("prio.skip", 64'(skip_cnt), 64'd3);

    // Saturation of the skip counter.
    input_bitwidth = 3'b100;
    data_in        = '0;
    in_valid       = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    in_valid = 1'b0;
    check_eq("sat.skip", 64'(skip_cnt), 64'hFFFF);
    expect_idle_out("sat.nobeat");

    // Reset mid-word discards everything.
    send(3'b100, 32'h44332211);
    tick();
    expect_beat("mrst.b1", 32'h22222222, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("mrst.valid", 64'(out_valid), 64'd0);
    check_eq("mrst.data",  64'(data_out),  64'd0);
    check_eq("mrst.last",  64'(out_last),  64'd0);
    check_eq("mrst.skip",  64'(skip_cnt),  64'd0);
    check_eq("mrst.err",   64'(err_mode),  64'd0);
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_idle_out("mrst.nobeat");
    end
    check_eq("mrst.in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
